// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd).
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       serial,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  hold, hold_n;
    logic        ready_n;
    logic        serial_n, busy_n, done_n;
    logic        bit_end, load;

`ifdef UART_TX_PARITY_EN
    logic par, par_n;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shift_n  = shift;
        hold_n   = hold;
        ready_n  = tx_ready;
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        serial_n = 1'b1;
        busy_n   = 1'b1;
        done_n   = 1'b0;
        load     = 1'b0;
        bit_end  = (cnt == LAST);

        // tx_ready is the "holding register empty" flag itself
        if (tx_valid && tx_ready) begin
            hold_n  = tx_byte;
            ready_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                load = !tx_ready;
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    load    = !tx_ready;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        if (load) begin
            state_n = START;
            shift_n = hold;
            ready_n = 1'b1;
            cnt_n   = '0;
            idx_n   = '0;
`ifdef UART_TX_PARITY_EN
            par_n   = ^hold ^ PARITY_ODD;
`endif
        end

        // outputs are registered, so derive them from the next state
        unique case (state_n)
            IDLE:   busy_n = 1'b0;
            START:  serial_n = 1'b0;
            DATA:   serial_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: serial_n = par_n;
`endif
            STOP:   done_n = (cnt_n == LAST);
            default: begin
                serial_n = 1'b1;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            hold     <= '0;
            tx_ready <= 1'b1;
            serial   <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            hold     <= hold_n;
            tx_ready <= ready_n;
            serial   <= serial_n;
            busy     <= busy_n;
            tx_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule
